uart_rx: RTL

16x-oversampling UART receiver, the receive-side counterpart of `uart_tx` in the UART/SPI bridge. Recovers 8N1 frames from the asynchronous `rx` pin using the shared `tick_16x` baud strobe. Delivers each byte with a one-cycle valid strobe to the bridge core, and flags framing errors.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Frame constants and receiver state encoding shared by the
//               UART transmit and receive blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int CNT_W      = $clog2(OVERSAMPLE);
    localparam int DATA_BITS  = 8;
    localparam int IDX_W      = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] SMP_A   = CNT_W'(7);
    localparam logic [CNT_W-1:0] SMP_B   = CNT_W'(8);
    localparam logic [CNT_W-1:0] SMP_C   = CNT_W'(9);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(15);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-stage synchronizer for an asynchronous, idle-high input;
//               both stages reset to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampling 8N1 UART receiver with 2-of-3 majority
//               sampling, valid strobe and framing-error strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_16x,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    logic                 w_rx_s;
    logic                 w_bit;
    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_tick_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_smp_a;
    logic                 r_smp_b;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_busy;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // Third vote is the live sample at SMP_C, so the decision lands on that tick.
    assign w_bit = majority3(r_smp_a, r_smp_b, w_rx_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_smp_a     <= 1'b1;
            r_smp_b     <= 1'b1;
            r_shift     <= '0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (tick_16x) begin
                if (r_tick_cnt == SMP_A) r_smp_a <= w_rx_s;
                if (r_tick_cnt == SMP_B) r_smp_b <= w_rx_s;
                case (r_state)
                    ST_IDLE: begin
                        // Detection tick is count 0 of the start bit.
                        if (!w_rx_s) begin
                            r_state    <= ST_START;
                            r_tick_cnt <= CNT_W'(1);
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_START: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        if (r_tick_cnt == SMP_C && w_bit) begin
                            r_state    <= ST_IDLE;
                            r_tick_cnt <= '0;
                            r_busy     <= 1'b0;
                        end else if (r_tick_cnt == BIT_END) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        if (r_tick_cnt == SMP_C) begin
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        end
                        if (r_tick_cnt == BIT_END) begin
                            if (r_bit_idx == LAST_BIT) r_state <= ST_STOP;
                            else                       r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        // Leave mid-stop-bit so a back-to-back start edge is caught.
                        if (r_tick_cnt == SMP_C) begin
                            r_tick_cnt <= '0;
                            r_busy     <= 1'b0;
                            if (w_bit) begin
                                r_state    <= ST_IDLE;
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_state     <= ST_BREAK;
                                r_frame_err <= 1'b1;
                            end
                        end
                    end
                    ST_BREAK: begin
                        if (w_rx_s) r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_busy;

endmodule
`default_nettype wire
